// File: rtl/wbu_pc_stage_if.sv
// Writeback/PC stage bus: EXU accept handshake, IFU hand-off and write strobes.
interface wbu_pc_stage_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 64
);
  logic              exu_valid;
  logic              wbu_ready;
  logic              wbu_valid;
  logic              ifu_ready;
  logic [1:0]        pc_mode;
  logic              br_taken;
  logic [XLEN-1:0]   imm;
  logic [XLEN-1:0]   rs1;
  logic [XLEN-1:0]   csr_target;
  logic [XLEN-1:0]   mtvec;
  logic              regw;
  logic              csrw;
  logic [XLEN-1:0]   pc;
  logic              regwen;
  logic              csrwen;
  logic              trap;
  logic [XLEN-1:0]   trap_epc;
  logic [CNT_W-1:0]  retire_cnt;

  // Stage side
  modport slave (
    input  exu_valid, ifu_ready, pc_mode, br_taken, imm, rs1, csr_target, mtvec, regw, csrw,
    output wbu_ready, wbu_valid, pc, regwen, csrwen, trap, trap_epc, retire_cnt
  );

  // EXU/IFU side
  modport master (
    output exu_valid, ifu_ready, pc_mode, br_taken, imm, rs1, csr_target, mtvec, regw, csrw,
    input  wbu_ready, wbu_valid, pc, regwen, csrwen, trap, trap_epc, retire_cnt
  );
endinterface

// File: rtl/wbu_pc_stage.sv
// Writeback/PC stage: registers the next PC, strobes RF/CSR writes, counts retires.
// Optional WBU_MISALIGN_TRAP_EN: misaligned targets trap to mtvec instead of being force-aligned.
module wbu_pc_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h3000_0000),
  parameter int unsigned     CNT_W    = 64,
  parameter int unsigned     IALIGN   = 4
) (
  input logic                clk,
  input logic                rst,
  wbu_pc_stage_if.slave      bus
);
  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);

  typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             acc;
  logic             hand;
  logic             retire;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  tgt;
  logic [XLEN-1:0]  nxt;
  logic [CNT_W-1:0] cnt_q;

  // State register; reset lands in HOLD so the IFU fetches RESET_PC
  always_ff @(posedge clk) begin
    if (rst) state <= HOLD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (acc) state_nxt = HOLD;
      HOLD:    if (hand && !acc) state_nxt = IDLE;
      default: state_nxt = HOLD;
    endcase
  end

  // Ready in HOLD follows the IFU so accept and hand-off can share a cycle
  always_comb begin
    bus.wbu_valid = (state == HOLD);
    bus.wbu_ready = (state == IDLE) | bus.ifu_ready;
  end

  assign acc  = bus.exu_valid & bus.wbu_ready & ~rst;
  assign hand = bus.wbu_valid & bus.ifu_ready;

  // Raw branch/jump target, modulo 2^XLEN
  always_comb begin
    tgt = pc_q + XLEN'(4);
    unique case (bus.pc_mode)
      2'd1:    if (bus.br_taken) tgt = pc_q + bus.imm;
      2'd2:    tgt = (bus.rs1 + bus.imm) & ~XLEN'(1);
      2'd3:    tgt = bus.csr_target;
      default: tgt = pc_q + XLEN'(4);
    endcase
  end

`ifdef WBU_MISALIGN_TRAP_EN
  logic            mis;
  logic            trap_q;
  logic [XLEN-1:0] epc_q;

  assign mis    = |(tgt & ALIGN_MASK);
  assign nxt    = mis ? bus.mtvec : tgt;
  assign retire = acc & ~mis;

  // Faulting instruction does not retire; trap pulses the cycle after accept
  always_ff @(posedge clk) begin
    if (rst) begin
      trap_q <= 1'b0;
      epc_q  <= '0;
    end else begin
      trap_q <= acc & mis;
      if (acc && mis) epc_q <= pc_q;
    end
  end

  assign bus.trap     = trap_q;
  assign bus.trap_epc = epc_q;
`else
  logic unused_mtvec;

  assign unused_mtvec = ^bus.mtvec;
  assign nxt          = tgt & ~ALIGN_MASK;
  assign retire       = acc;
  assign bus.trap     = 1'b0;
  assign bus.trap_epc = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      cnt_q <= '0;
    end else begin
      if (acc)    pc_q  <= nxt;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.pc         = pc_q;
  assign bus.retire_cnt = cnt_q;
  assign bus.regwen     = retire & bus.regw;
  assign bus.csrwen     = retire & bus.csrw;
endmodule

// File: doc/wbu_pc_stage.md
Name: wbu_pc_stage

Overview:
- Parametrised next-generation writeback/PC stage of the multi-cycle core.
- Accepts one executed instruction from the EXU over a valid/ready handshake.
- Computes and registers the next PC, gates register-file and CSR write enables to the accept cycle, and hands the new PC to the IFU.
- Added over the previous generation:
  - full-throughput handshake (accept and hand-off in the same cycle);
  - encoded next-PC modes with branch-taken input;
  - misaligned-target detection;
  - retired-instruction counter.

Parameters:
- XLEN, 32, datapath/PC width.
- RESET_PC, 32'h3000_0000, PC value loaded at reset.
- CNT_W, 64, width of the retire counter.
- IALIGN, 4, required target alignment in bytes (4 or 2).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- exu_valid  in  1  EXU holds a completed instruction
- wbu_ready  out  1  stage can accept this cycle
- wbu_valid  out  1  pc output is a valid fetch address for the IFU
- ifu_ready  in  1  IFU accepts pc
- pc_mode  in  2  0=SEQ (pc+4), 1=PCREL (pc+imm if br_taken, else pc+4), 2=JALR ((rs1+imm)&~1), 3=CSR (csr_target)
- br_taken  in  1  branch condition result; used only when pc_mode=1
- imm  in  XLEN  immediate
- rs1  in  XLEN  rs1 operand
- csr_target  in  XLEN  mtvec/mepc value for ecall/mret
- mtvec  in  XLEN  trap vector
- regw  in  1  instruction writes the register file
- csrw  in  1  instruction writes a CSR
- pc  out  XLEN  current PC register
- regwen  out  1  register-file write strobe
- csrwen  out  1  CSR write strobe
- trap  out  1  one-cycle misaligned-target trap pulse
- trap_epc  out  XLEN  PC of the faulting instruction
- retire_cnt  out  CNT_W  instructions retired

Behaviour:
- acc = exu_valid & wbu_ready; hand = wbu_valid & ifu_ready.
- State machine, 2 states:
  - IDLE: wbu_valid=0.
  - HOLD: wbu_valid=1.
- wbu_ready = (state==IDLE) | ifu_ready, so an accept can coincide with a hand-off.
- Transitions:
  - IDLE, acc → HOLD.
  - HOLD, hand & !acc → IDLE.
  - HOLD, hand & acc → HOLD, with the new pc presented next cycle.
  - HOLD, !hand → HOLD, with pc stable.
- Reset: state=HOLD, so wbu_valid=1 and the IFU fetches RESET_PC. Other reset values: pc=RESET_PC, retire_cnt=0, trap=0, trap_epc=0. regwen and csrwen are 0 while rst is high.
- A reset asserted mid-transaction discards the pending instruction. No write strobe fires in a reset cycle.
- Next-PC arithmetic:
  - nxt is computed combinationally from the current pc.
  - All additions are modulo 2^XLEN; wrap-around is silent.
  - pc <= nxt on the acc edge only.
- Latency: the instruction is accepted in cycle N. The new pc is visible and wbu_valid=1 in cycle N+1.
- regwen = acc & regw; csrwen = acc & csrw. Both are combinational and exactly one cycle wide per accepted instruction.
- retire_cnt increments by 1 on each acc. It wraps from 2^CNT_W-1 to 0.
- Misalignment: mis = (nxt mod IALIGN) != 0, evaluated only on acc. Handling depends on the optional feature below.
- rs1, imm and the other control inputs are sampled only in the acc cycle. They are don't-care otherwise.

Optional Feature:
- Macro: WBU_MISALIGN_TRAP_EN.
- Defined:
  - On acc with mis=1, pc <= mtvec instead of nxt.
  - trap pulses for 1 cycle (the cycle after acc) and trap_epc <= the old pc.
  - regwen and csrwen are suppressed for that instruction.
  - retire_cnt does not increment.
- Undefined:
  - The low log2(IALIGN) bits of nxt are forced to 0.
  - trap is tied 0 and trap_epc is tied 0.
  - regwen, csrwen and retire_cnt behave normally.

Test Plan:
- Reset boot: rst high 2 cycles, then low → pc=32'h3000_0000, wbu_valid=1. With ifu_ready=1 → next cycle wbu_valid=0, wbu_ready=1.
- SEQ then PCREL:
  - Accept pc_mode=0 → pc=32'h3000_0004.
  - Accept pc_mode=1, imm=-8, br_taken=1 → pc=32'h2FFF_FFFC.
  - Same but br_taken=0 → pc+4.
  - regwen pulses 1 cycle each time regw=1.
- JALR/CSR:
  - rs1=32'h8000_0003, imm=0, pc_mode=2 → pc=32'h8000_0002 (IALIGN=2).
  - pc_mode=3, csr_target=32'h8000_0100 → pc=32'h8000_0100.
  - csrw=1 → csrwen pulses once.
- Back-to-back throughput: hold exu_valid=1 and ifu_ready=1 for 10 cycles → 10 accepts, retire_cnt=10, wbu_valid stays 1. Stall ifu_ready=0 for 3 cycles → wbu_ready=0 and pc stable.
- Misaligned trap (IALIGN=4, macro defined): pc_mode=2, rs1=32'h8000_0002, mtvec=32'h8000_0400 → pc=32'h8000_0400, trap=1 for one cycle, trap_epc=old pc, no regwen, retire_cnt unchanged. With the macro undefined → pc=32'h8000_0000 and trap=0.
- Wrap/reset: CNT_W=4 with 17 accepts → retire_cnt=1. Assert rst in the same cycle as acc → no regwen, pc=RESET_PC, retire_cnt=0.
